// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the fetch-stage branch predictor: branch variants as decoded
// by the control unit, and the 2-bit saturating counter states.
package branch_predictor_pkg;

  typedef enum logic [2:0] {
    BV_NONE      = 3'd0,
    BV_BEQ       = 3'd1,
    BV_BNE       = 3'd2,
    BV_BLTZ      = 3'd3,
    BV_JUMP      = 3'd4,
    BV_JUMP_LINK = 3'd5,
    BV_JUMP_REG  = 3'd6
  } branch_variant_e;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  function automatic logic is_cond(input logic [2:0] variant);
    return (variant == BV_BEQ) || (variant == BV_BNE) || (variant == BV_BLTZ);
  endfunction

  function automatic logic is_jump(input logic [2:0] variant);
    return (variant == BV_JUMP) || (variant == BV_JUMP_LINK) || (variant == BV_JUMP_REG);
  endfunction

  // Saturating step: never wraps past strongly-taken or strongly-not-taken.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == BP_ST) ? BP_ST : ctr + 2'd1;
    else       return (ctr == BP_SNT) ? BP_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_return_stack.sv
// Circular return-address stack: push overwrites the oldest slot when full,
// pop on empty is ignored, top is the most recent push.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_top,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_ptr] <= i_push_data;
      r_ptr        <= r_ptr + PTR_W'(1);
      if (r_count != CNT_W'(DEPTH)) r_count <= r_count + CNT_W'(1);
    end else if (i_pop && (r_count != '0)) begin
      r_ptr   <= r_ptr - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_top   = r_mem[r_ptr - PTR_W'(1)];
  assign o_count = r_count;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters plus decode-stage misprediction check.
// Optional return-address stack enabled by defining BP_RAS_EN.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int TAG_W     = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        stall,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [2:0]  upd_variant,
  input  logic        upd_is_return,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [29:0]       r_target [ENTRIES];
  logic [1:0]        r_ctr    [ENTRIES];
  logic              r_is_ret [ENTRIES];

  logic [IDX_W-1:0]  w_f_idx;
  logic [TAG_W-1:0]  w_f_tag;
  logic              w_f_hit;
  logic [31:0]       w_f_plus4;
  logic [31:0]       w_btb_target;
  logic [IDX_W-1:0]  w_u_idx;
  logic [TAG_W-1:0]  w_u_tag;
  logic              w_u_hit;
  logic              w_taken;
  logic              w_commit;
  logic              w_we;
  logic              w_we_target;
  logic              w_we_meta;
  logic [1:0]        w_new_ctr;
  logic              w_new_is_ret;
  logic              w_unused;

  // Fetch-side lookup
  assign w_f_idx      = fetch_pc[IDX_W+1:2];
  assign w_f_tag      = fetch_pc[IDX_W+2 +: TAG_W];
  assign w_f_hit      = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign w_f_plus4    = fetch_pc + 32'd4;
  assign w_btb_target = {r_target[w_f_idx], 2'b00};
  assign pred_taken   = w_f_hit && r_ctr[w_f_idx][1];

`ifdef BP_RAS_EN
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  logic [31:0]      w_ras_top;
  logic [CNT_W-1:0] w_ras_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = w_commit && (upd_variant == BV_JUMP_LINK);
  assign w_pop  = w_commit && (upd_variant == BV_JUMP_REG) && upd_is_return;

  return_stack #(.DEPTH(RAS_DEPTH), .WIDTH(32), .CNT_W(CNT_W)) u_ras (
    .clk         (clock),
    .rst_n       (reset_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (upd_pc + 32'd4),
    .o_top       (w_ras_top),
    .o_count     (w_ras_count)
  );

  always_comb begin
    pred_target = w_f_plus4;
    if (pred_taken) begin
      if (r_is_ret[w_f_idx] && (w_ras_count != '0)) pred_target = w_ras_top;
      else                                           pred_target = w_btb_target;
    end
  end
`else
  assign pred_target = pred_taken ? w_btb_target : w_f_plus4;
`endif

  // Decode-side check; an unresolved direction on non-branches counts as not taken
  assign w_taken     = upd_taken && (upd_variant != BV_NONE);
  assign mispredict  = upd_valid && ((w_taken != upd_pred_taken) ||
                       (w_taken && upd_pred_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = w_taken ? upd_target : upd_pc + 32'd4;

  assign w_u_idx  = upd_pc[IDX_W+1:2];
  assign w_u_tag  = upd_pc[IDX_W+2 +: TAG_W];
  assign w_u_hit  = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_commit = upd_valid && !stall && (upd_variant != BV_NONE);

  always_comb begin
    w_we         = 1'b0;
    w_we_target  = 1'b0;
    w_we_meta    = 1'b0;
    w_new_ctr    = r_ctr[w_u_idx];
    w_new_is_ret = 1'b0;
    if (w_commit) begin
      if (is_jump(upd_variant)) begin
        w_we         = 1'b1;
        w_we_target  = 1'b1;
        w_we_meta    = 1'b1;
        w_new_ctr    = BP_ST;
        w_new_is_ret = upd_is_return;
      end else if (is_cond(upd_variant)) begin
        if (w_u_hit) begin
          w_we        = 1'b1;
          w_we_target = w_taken;
          w_new_ctr   = ctr_step(r_ctr[w_u_idx], w_taken);
        end else if (w_taken) begin
          // Not-taken misses are not worth displacing whatever lives here
          w_we        = 1'b1;
          w_we_target = 1'b1;
          w_we_meta   = 1'b1;
          w_new_ctr   = BP_WT;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= BP_WNT;
        r_is_ret[i] <= 1'b0;
      end
    end else if (w_we) begin
      r_ctr[w_u_idx] <= w_new_ctr;
      if (w_we_target) r_target[w_u_idx] <= upd_target[31:2];
      if (w_we_meta) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_is_ret[w_u_idx] <= w_new_is_ret;
      end
    end
  end

  // Address bits outside index/tag, and is_ret when no stack is built
  assign w_unused = ^{fetch_pc[1:0], fetch_pc[31:IDX_W+2+TAG_W], upd_pc[1:0],
                      upd_pc[31:IDX_W+2+TAG_W], upd_target[1:0], r_is_ret[w_f_idx]};

endmodule
